axilite_master_arbiter: RTL and testbench
=========================================

Name: axilite_master_arbiter

Overview:
Shares one axilite_master backend port (bk_* start/done interface) between NUM_REQ requesters, e.g. config sequencer, mailbox and debug bridge.
- Arbitration is round-robin.
- Exactly one transaction (write or read) is in flight at a time.
- Each requester gets a valid/ready request handshake and a done pulse with read data.
- Sits directly in front of axilite_master, in the same axi_aclk domain.

Parameters:
NUM_REQ, 2, number of requesters, legal range 2..4
IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridden)

Ports:
axi_aclk  input  1  clock; one clock for the whole block
axi_aresetn  input  1  asynchronous active-low reset
rq_valid  input  NUM_REQ  per-requester request valid (level)
rq_wr  input  NUM_REQ  1 = write, 0 = read
rq_addr  input  32*NUM_REQ  packed addresses; requester i at [32i+:32]
rq_wdata  input  32*NUM_REQ  packed write data
rq_wstrb  input  4*NUM_REQ  packed byte strobes
rq_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
rq_done  output  NUM_REQ  one-cycle completion pulse to the granted requester
rq_rdata  output  32  read data, valid in the rq_done cycle of a read
bk_wstart  output  1  write start pulse to master
bk_waddr  output  32  write address
bk_wdata  output  32  write data
bk_wstrb  output  4  write strobes
bk_wdone  input  1  write completion pulse from master
bk_rstart  output  1  read start pulse to master
bk_raddr  output  32  read address
bk_rdata  input  32  read data, valid while bk_rdone=1
bk_rdone  input  1  read completion pulse from master

Behaviour:
- Reset (asynchronous, axi_aresetn=0): state=IDLE, rr_ptr=0, grant=0. All outputs are 0: rq_ready, rq_done, rq_rdata, bk_wstart, bk_rstart, bk_waddr, bk_wdata, bk_wstrb, bk_raddr. Reset mid-transaction abandons it; no done is issued.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If any rq_valid is high, the picker selects the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On the next edge it registers grant, is_wr, addr, wdata and wstrb of the winner, then goes to ISSUE.
  - If no rq_valid is high, it stays in IDLE.
- ISSUE (exactly 1 cycle):
  - bk_wstart=1 if is_wr, else bk_rstart=1.
  - bk_waddr/bk_wdata/bk_wstrb or bk_raddr are driven from the registers.
  - rq_ready[grant]=1 in this same cycle.
  - Next state: WAIT_DONE.
- Handshake rule: a requester holds rq_valid and stable payload until it sees rq_ready; rq_valid is sampled only in IDLE. Dropping rq_valid before grant is legal (request withdrawn).
- Address/data outputs hold their registered values until the next ISSUE; they are not cleared. Start pulses are single-cycle.
- WAIT_DONE:
  - Waits for bk_wdone (write) or bk_rdone (read), whichever matches is_wr. The non-matching done is ignored.
  - On the matching done, on the next edge: rq_done[grant]=1 for one cycle; rq_rdata<=bk_rdata (read only, otherwise unchanged); rr_ptr<=(grant+1) mod NUM_REQ; state->IDLE.
- Latency:
  - rq_valid high in IDLE at cycle 0 -> bk_*start and rq_ready at cycle 1.
  - Master done at cycle k -> rq_done at k+1.
  - The next grant is decided at k+1 and issued at k+2.
- Done pulses arriving in IDLE or ISSUE are ignored (protocol violation; no state change).
- A requester may re-raise rq_valid in the same cycle as its rq_done; it then competes normally. Round-robin guarantees the others are served first.
- Starvation bound: a continuously valid requester is granted within NUM_REQ transactions.

Optional Feature:
Macro ARB_FIXED_PRIO_EN.
- Defined: strict fixed priority, requester 0 highest, then ascending index; rr_ptr is neither used nor updated.
- Undefined: round-robin as above.
- All ports and timing are identical either way.

Decomposition:
- Package axilite_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_DONE) as logic [1:0];
  - localparams MAX_REQ=4, ADDR_W=32, DATA_W=32, STRB_W=4.
- One combinational sub-module, axilite_rr_pick:
  - inputs: req[NUM_REQ], ptr[IDX_W];
  - outputs: gnt_idx, gnt_any;
  - holds the rotate-and-priority-encode logic and the ARB_FIXED_PRIO_EN switch.

Test Plan:
1. Single write: rq_valid[0]=1, wr=1, addr=0x3000_0010, wdata=0xA5A5_0001, wstrb=0xF -> bk_wstart=1 at cycle 1 carrying those values, rq_ready[0] in the same cycle. bk_wdone at cycle 5 -> rq_done[0] at cycle 6, rq_rdata unchanged.
2. Single read: rq1 read addr=0x3000_0004; master returns bk_rdata=0x1234_5678 with bk_rdone -> rq_done[1] next cycle with rq_rdata=0x1234_5678; bk_wstart never asserted.
3. Contention: rq0 and rq1 held valid continuously from reset -> grants alternate 0,1,0,1 over 4 transactions. With ARB_FIXED_PRIO_EN, all 4 go to 0 and rq1 never gets rq_ready while rq0 stays valid.
4. Wrong done: during a read, inject bk_wdone -> no rq_done, state stays WAIT_DONE. The later bk_rdone completes normally.
5. Reset mid-op: assert axi_aresetn=0 in WAIT_DONE -> all outputs 0 immediately. After release with rq_valid[1]=1, the first grant goes to 1 (rr_ptr=0, rq0 idle) at cycle 1.
6. Back-to-back: in the rq_done cycle, rq0 re-raises a write while rq1 is waiting -> the next grant goes to 1, and bk_rstart/bk_wstart asserts exactly 2 cycles after the previous master done.

Source files
------------

// File: rtl/axilite_arb_pkg.sv
// Shared types and constants for the axilite_master requester arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT_DONE)
//   MAX_REQ     : largest supported requester count
//   ADDR_W, DATA_W, STRB_W : AXI-Lite address / data / strobe widths
package axilite_arb_pkg;

    localparam int MAX_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axilite_rr_pick.sv
// Combinational requester picker.
// Default build: round-robin, the first set bit of req scanning
// ptr, ptr+1, ... modulo NUM_REQ.
// With ARB_FIXED_PRIO_EN defined: strict fixed priority, requester 0
// highest; ptr is ignored.
// Ports:
//   req     [NUM_REQ] in  : request vector
//   ptr     [IDX_W]   in  : round-robin start index
//   gnt_idx [IDX_W]   out : winning requester index (0 when none)
//   gnt_any           out : at least one request is set
module axilite_rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req[i]) begin
                gnt_idx = IDX_W'(i);
                gnt_any = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned    sum;
            logic [IDX_W-1:0] cand;
            // ptr + i never reaches 2*NUM_REQ, so one subtraction wraps it
            sum = 32'(ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (!gnt_any && req[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/axilite_master_arbiter.sv
// Shares one axilite_master backend (bk_* start/done interface) between
// NUM_REQ requesters, one transaction in flight at a time.
// Arbitration is round-robin; define ARB_FIXED_PRIO_EN for strict fixed
// priority (requester 0 highest). Ports and timing are identical either way.
// Ports:
//   axi_aclk, axi_aresetn           : clock, async active-low reset
//   rq_valid/rq_wr [NUM_REQ]        : per-requester request level and direction
//   rq_addr/rq_wdata [32*NUM_REQ]   : packed payload, requester i at [32i+:32]
//   rq_wstrb [4*NUM_REQ]            : packed byte strobes
//   rq_ready/rq_done [NUM_REQ]      : accept / completion pulses to the grantee
//   rq_rdata [32]                   : read data, valid with rq_done of a read
//   bk_wstart/bk_waddr/bk_wdata/bk_wstrb, bk_wdone : backend write channel
//   bk_rstart/bk_raddr, bk_rdata/bk_rdone          : backend read channel
module axilite_master_arbiter
    import axilite_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [NUM_REQ-1:0]        rq_valid,
    input  logic [NUM_REQ-1:0]        rq_wr,
    input  logic [ADDR_W*NUM_REQ-1:0] rq_addr,
    input  logic [DATA_W*NUM_REQ-1:0] rq_wdata,
    input  logic [STRB_W*NUM_REQ-1:0] rq_wstrb,
    output logic [NUM_REQ-1:0]        rq_ready,
    output logic [NUM_REQ-1:0]        rq_done,
    output logic [DATA_W-1:0]         rq_rdata,
    output logic                      bk_wstart,
    output logic [ADDR_W-1:0]         bk_waddr,
    output logic [DATA_W-1:0]         bk_wdata,
    output logic [STRB_W-1:0]         bk_wstrb,
    input  logic                      bk_wdone,
    output logic                      bk_rstart,
    output logic [ADDR_W-1:0]         bk_raddr,
    input  logic [DATA_W-1:0]         bk_rdata,
    input  logic                      bk_rdone
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic             is_wr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             done_match;
    logic             capture;

    axilite_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (rq_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // only the done matching the in-flight direction completes it
    assign done_match = is_wr ? bk_wdone : bk_rdone;
    assign capture    = (state == IDLE) && pick_any;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rq_ready  = '0;
        bk_wstart = 1'b0;
        bk_rstart = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bk_wstart       = is_wr;
                bk_rstart       = !is_wr;
                rq_ready[grant] = 1'b1;
                state_nxt       = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_match) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload is loaded straight into the backend output registers on
    // grant, so they present it during ISSUE and hold it afterwards.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rr_ptr   <= '0;
            grant    <= '0;
            is_wr    <= 1'b0;
            rq_done  <= '0;
            rq_rdata <= '0;
            bk_waddr <= '0;
            bk_wdata <= '0;
            bk_wstrb <= '0;
            bk_raddr <= '0;
        end else begin
            rq_done <= '0;
            if (capture) begin
                grant <= pick_idx;
                is_wr <= rq_wr[pick_idx];
                if (rq_wr[pick_idx]) begin
                    bk_waddr <= rq_addr[pick_idx*ADDR_W +: ADDR_W];
                    bk_wdata <= rq_wdata[pick_idx*DATA_W +: DATA_W];
                    bk_wstrb <= rq_wstrb[pick_idx*STRB_W +: STRB_W];
                end else begin
                    bk_raddr <= rq_addr[pick_idx*ADDR_W +: ADDR_W];
                end
            end
            if ((state == WAIT_DONE) && done_match) begin
                rq_done[grant] <= 1'b1;
                if (!is_wr) begin
                    rq_rdata <= bk_rdata;
                end
`ifndef ARB_FIXED_PRIO_EN
                rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_axilite_master_arbiter.sv
module tb_axilite_master_arbiter;

    localparam int N = 3;

    logic            axi_aclk = 1'b0;
    logic            axi_aresetn;
    logic [N-1:0]    rq_valid;
    logic [N-1:0]    rq_wr;
    logic [32*N-1:0] rq_addr;
    logic [32*N-1:0] rq_wdata;
    logic [4*N-1:0]  rq_wstrb;
    logic [N-1:0]    rq_ready;
    logic [N-1:0]    rq_done;
    logic [31:0]     rq_rdata;
    logic            bk_wstart;
    logic [31:0]     bk_waddr;
    logic [31:0]     bk_wdata;
    logic [3:0]      bk_wstrb;
    logic            bk_wdone;
    logic            bk_rstart;
    logic [31:0]     bk_raddr;
    logic [31:0]     bk_rdata;
    logic            bk_rdone;

    axilite_master_arbiter #(.NUM_REQ(N)) u_dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .rq_valid    (rq_valid),
        .rq_wr       (rq_wr),
        .rq_addr     (rq_addr),
        .rq_wdata    (rq_wdata),
        .rq_wstrb    (rq_wstrb),
        .rq_ready    (rq_ready),
        .rq_done     (rq_done),
        .rq_rdata    (rq_rdata),
        .bk_wstart   (bk_wstart),
        .bk_waddr    (bk_waddr),
        .bk_wdata    (bk_wdata),
        .bk_wstrb    (bk_wstrb),
        .bk_wdone    (bk_wdone),
        .bk_rstart   (bk_rstart),
        .bk_raddr    (bk_raddr),
        .bk_rdata    (bk_rdata),
        .bk_rdone    (bk_rdone)
    );

    always #5 axi_aclk = ~axi_aclk;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int          m_ptr;
    logic [31:0] e_waddr, e_wdata, e_raddr, e_rdata;
    logic [3:0]  e_wstrb;

    // per-requester payloads
    logic [31:0] p_addr  [N];
    logic [31:0] p_wdata [N];
    logic [3:0]  p_wstrb [N];
    logic        p_wr    [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // winner chosen from the arbitration rule, not from any RTL structure
    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
`endif
        return -1;
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            p_addr[i]  = $urandom;
            p_wdata[i] = $urandom;
            p_wstrb[i] = 4'($urandom);
            p_wr[i]    = 1'($urandom);
        end
    endtask

    task automatic drive_payload();
        for (int i = 0; i < N; i++) begin
            rq_addr[32*i +: 32] = p_addr[i];
            rq_wdata[32*i +: 32] = p_wdata[i];
            rq_wstrb[4*i +: 4]  = p_wstrb[i];
            rq_wr[i]            = p_wr[i];
        end
    endtask

    task automatic chk_bus(input string tag);
        chk({tag, "_waddr"}, bk_waddr, e_waddr);
        chk({tag, "_wdata"}, bk_wdata, e_wdata);
        chk({tag, "_wstrb"}, 32'(bk_wstrb), 32'(e_wstrb));
        chk({tag, "_raddr"}, bk_raddr, e_raddr);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"},  32'(rq_ready), 32'd0);
        chk({tag, "_wstart"}, 32'(bk_wstart), 32'd0);
        chk({tag, "_rstart"}, 32'(bk_rstart), 32'd0);
        chk({tag, "_done"},   32'(rq_done), 32'd0);
    endtask

    // One arbitration round starting at #1 after an edge with the DUT in IDLE.
    // stray_w/stray_r: with no request, inject stray dones in IDLE.
    task automatic txn(input logic [N-1:0] vld, input int wait_cyc, input bit wrong_done,
                       input bit early_done, input logic [31:0] rdata);
        int          w;
        bit          wr;
        logic [31:0] oh;
        drive_payload();
        rq_valid = vld;
        w = model_pick(vld, m_ptr);
        if (w < 0) begin
            bk_wdone = early_done;
            bk_rdone = wrong_done;
            bk_rdata = rdata;
            @(posedge axi_aclk); #1;
            bk_wdone = 1'b0;
            bk_rdone = 1'b0;
            chk_quiet("idle");
            chk("idle_rdata", rq_rdata, e_rdata);
            return;
        end
        wr = p_wr[w];
        oh = 32'd1 << w;
        @(posedge axi_aclk); #1;
        if (wr) begin
            e_waddr = p_addr[w];
            e_wdata = p_wdata[w];
            e_wstrb = p_wstrb[w];
        end else begin
            e_raddr = p_addr[w];
        end
        chk("issue_ready", 32'(rq_ready), oh);
        chk("issue_wstart", 32'(bk_wstart), 32'(wr));
        chk("issue_rstart", 32'(bk_rstart), 32'(!wr));
        chk("issue_done", 32'(rq_done), 32'd0);
        chk_bus("issue");
        rq_valid[w] = 1'b0;
        if (early_done) begin
            bk_wdone = wr;
            bk_rdone = !wr;
        end
        @(posedge axi_aclk); #1;
        bk_wdone = 1'b0;
        bk_rdone = 1'b0;
        for (int k = 0; k <= wait_cyc; k++) begin
            chk_quiet("wait");
            chk_bus("wait");
            if (k == wait_cyc) begin
                if (wr) bk_wdone = 1'b1;
                else begin
                    bk_rdone = 1'b1;
                    bk_rdata = rdata;
                end
            end else if (wrong_done && k == 0) begin
                if (wr) begin
                    bk_rdone = 1'b1;
                    bk_rdata = ~rdata;
                end else begin
                    bk_wdone = 1'b1;
                end
            end
            @(posedge axi_aclk); #1;
            bk_wdone = 1'b0;
            bk_rdone = 1'b0;
            bk_rdata = $urandom;
        end
        if (!wr) e_rdata = rdata;
        chk("done_pulse", 32'(rq_done), oh);
        chk("done_rdata", rq_rdata, e_rdata);
        chk("done_ready", 32'(rq_ready), 32'd0);
        chk("done_wstart", 32'(bk_wstart), 32'd0);
        chk("done_rstart", 32'(bk_rstart), 32'd0);
`ifndef ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % N;
`endif
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        e_waddr = '0;
        e_wdata = '0;
        e_wstrb = '0;
        e_raddr = '0;
        e_rdata = '0;
    endtask

    initial begin
        axi_aresetn = 1'b0;
        rq_valid = '0;
        rq_wr    = '0;
        rq_addr  = '0;
        rq_wdata = '0;
        rq_wstrb = '0;
        bk_wdone = 1'b0;
        bk_rdone = 1'b0;
        bk_rdata = '0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            p_addr[i] = '0; p_wdata[i] = '0; p_wstrb[i] = '0; p_wr[i] = 1'b0;
        end

        // reset state
        repeat (2) @(posedge axi_aclk);
        #1;
        chk_quiet("rst");
        chk_bus("rst");
        chk("rst_rdata", rq_rdata, 32'd0);
        @(negedge axi_aresetn or negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk); #1;

        // single write from requester 0, master done at cycle 5
        p_wr[0] = 1'b1; p_addr[0] = 32'h3000_0010; p_wdata[0] = 32'hA5A5_0001; p_wstrb[0] = 4'hF;
        txn(3'b001, 3, 1'b0, 1'b0, 32'hDEAD_BEEF);

        // single read from requester 1 with a stray write done mid-wait
        p_wr[1] = 1'b0; p_addr[1] = 32'h3000_0004;
        txn(3'b010, 2, 1'b1, 1'b0, 32'h1234_5678);

        // requesters 0 and 1 both continuously valid
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            txn(3'b011, int'($urandom_range(0, 2)), 1'b0, 1'b0, $urandom);
        end

        // randomized traffic: withdrawals, stray/early dones, back-to-back grants
        for (int i = 0; i < 150; i++) begin
            rand_payload();
            txn(N'($urandom_range(0, (1 << N) - 1)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), $urandom);
        end

        // reset while waiting for the master
        rand_payload();
        p_wr[0] = 1'b1;
        drive_payload();
        rq_valid = 3'b001;
        @(posedge axi_aclk); #1;
        rq_valid = '0;
        @(posedge axi_aclk); #1;
        axi_aresetn = 1'b0;
        #1;
        model_reset();
        chk_quiet("midrst");
        chk_bus("midrst");
        chk("midrst_rdata", rq_rdata, 32'd0);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk); #1;
        rand_payload();
        txn(3'b010, 1, 1'b0, 1'b0, $urandom);
        rand_payload();
        txn(3'b111, 0, 1'b0, 1'b0, $urandom);
        rq_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
